// File: rtl/pwm_capture_if.sv
// Control/result bundle between the PWM capture core and its register wrapper.
// The wrapper (or bench) is the master; the capture core is the slave.
interface pwm_capture_if #(
  parameter int CNT_W = 32
);
  logic             pwm_in;
  logic             en;
  logic [CNT_W-1:0] pre;
  logic             clr;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high;
  logic             valid;
  logic             done;
  logic             ovf;

  modport master (
    output pwm_in, en, pre, clr,
    input  period, high, valid, done, ovf
  );

  modport slave (
    input  pwm_in, en, pre, clr,
    output period, high, valid, done, ovf
  );
endinterface

// File: rtl/pwm_capture.sv
// PWM input capture: measures period and high time of pwm_in in prescaled ticks,
// between consecutive synchronized rising edges.
//
// state | meaning
// IDLE  | disabled, counters held at 0
// ARM   | waiting for first rise (partial period discarded)
// HIGH  | input high, counting, fall latches high time
// LOW   | input low, counting, rise reports period/high
module pwm_capture #(
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic          i_clk,
  input  logic          i_rst,
  pwm_capture_if.slave  cap_if
);

  typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_HIGH, ST_LOW} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_s_d;
  logic [CNT_W-1:0]       r_pre_cnt;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       r_hcap;
  logic [CNT_W-1:0]       r_period;
  logic [CNT_W-1:0]       r_high;
  logic                   r_valid;
  logic                   r_done;
  logic                   r_ovf;

  logic                   w_s;
  logic                   w_rise;
  logic                   w_fall;
  logic                   w_edge;
  logic                   w_tick;
  logic                   w_cnt_max;
  logic [CNT_W-1:0]       w_cnt_inc;
  logic                   w_run;
  logic                   w_restart;
  logic                   w_hcap_ld;
  logic                   w_capture;
  logic                   w_ovf_set;

  assign w_s       = r_sync[SYNC_STAGES-1];
  assign w_rise    = w_s & ~r_s_d;
  assign w_fall    = ~w_s & r_s_d;
  assign w_edge    = w_rise | w_fall;
  assign w_tick    = (r_pre_cnt == cap_if.pre);
  assign w_cnt_max = &r_cnt;
  // Saturating increment: a capture coincident with a full counter must not wrap to 0
  assign w_cnt_inc = w_cnt_max ? r_cnt : r_cnt + {{(CNT_W-1){1'b0}}, w_tick};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= '0;
      r_s_d  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], cap_if.pwm_in};
      r_s_d  <= w_s;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_run       = 1'b0;
    w_restart   = 1'b0;
    w_hcap_ld   = 1'b0;
    w_capture   = 1'b0;
    w_ovf_set   = 1'b0;
    if (!cap_if.en) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: w_state_nxt = ST_ARM;
        ST_ARM: begin
          if (w_rise) begin
            w_restart   = 1'b1;
            w_state_nxt = ST_HIGH;
          end
        end
        ST_HIGH: begin
          w_run = 1'b1;
          if (w_fall) begin
            w_hcap_ld   = 1'b1;
            w_state_nxt = ST_LOW;
          end else if (w_cnt_max && w_tick && !w_edge) begin
            w_ovf_set   = 1'b1;
            w_run       = 1'b0;
            w_state_nxt = ST_ARM;
          end
        end
        ST_LOW: begin
          w_run = 1'b1;
          if (w_rise) begin
            w_capture   = 1'b1;
            w_restart   = 1'b1;
            w_state_nxt = ST_HIGH;
          end else if (w_cnt_max && w_tick) begin
            w_ovf_set   = 1'b1;
            w_run       = 1'b0;
            w_state_nxt = ST_ARM;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pre_cnt <= '0;
      r_cnt     <= '0;
      r_hcap    <= '0;
    end else begin
      if (w_restart || !w_run) begin
        r_pre_cnt <= '0;
        r_cnt     <= '0;
      end else begin
        r_pre_cnt <= w_tick ? '0 : r_pre_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        r_cnt     <= w_cnt_inc;
      end
      if (w_hcap_ld) r_hcap <= w_cnt_inc;
    end
  end

  // A capture in the same cycle as clr wins; an overflow in the same cycle as clr is kept
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_period <= '0;
      r_high   <= '0;
      r_valid  <= 1'b0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_done <= w_capture;
      if (w_capture) begin
        r_period <= w_cnt_inc;
        r_high   <= r_hcap;
        r_valid  <= 1'b1;
      end else if (cap_if.clr) begin
        r_period <= '0;
        r_high   <= '0;
        r_valid  <= 1'b0;
      end
      if (w_ovf_set)       r_ovf <= 1'b1;
      else if (cap_if.clr) r_ovf <= 1'b0;
    end
  end

  assign cap_if.period = r_period;
  assign cap_if.high   = r_high;
  assign cap_if.valid  = r_valid;
  assign cap_if.done   = r_done;
  assign cap_if.ovf    = r_ovf;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture (CNT_W=8 so counter saturation is reachable quickly).
module tb_pwm_capture;
  localparam int CNT_W = 8;

  logic clk;
  logic rst;

  int n_checks;
  int n_fail;
  int done_total;

  int wf_per;
  int wf_high;
  int wf_phase;
  bit wf_on;

  pwm_capture_if #(.CNT_W(CNT_W)) cap_if ();

  pwm_capture #(.CNT_W(CNT_W), .SYNC_STAGES(2)) u_dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .cap_if (cap_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // PWM generator: pin changes on falling clk edges when enabled
  initial begin
    forever begin
      @(negedge clk);
      if (wf_on) begin
        cap_if.pwm_in = (wf_phase < wf_high);
        wf_phase = (wf_phase + 1 == wf_per) ? 0 : wf_phase + 1;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (cap_if.done === 1'b1) done_total++;
  end

  task automatic wait_done(input int budget, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (cap_if.done !== 1'b1 && cycles < budget);
  endtask

  task automatic restart_wave(input int per, input int hi, input logic [CNT_W-1:0] pre_v);
    cap_if.en = 1'b0;
    wf_on = 1'b0;
    @(negedge clk);
    cap_if.pwm_in = 1'b0;
    repeat (10) @(negedge clk);
    cap_if.pre = pre_v;
    wf_per = per;
    wf_high = hi;
    wf_phase = 0;
    wf_on = 1'b1;
    cap_if.en = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cap_if.en = 1'b0;
    cap_if.clr = 1'b0;
    cap_if.pre = '0;
    cap_if.pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (cap_if.period !== 8'd0) begin n_fail++; $display("FAIL reset_period got=%0d exp=0", cap_if.period); end
    n_checks++;
    if (cap_if.high !== 8'd0) begin n_fail++; $display("FAIL reset_high got=%0d exp=0", cap_if.high); end
    n_checks++;
    if (cap_if.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", cap_if.valid); end
    n_checks++;
    if (cap_if.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", cap_if.done); end
    n_checks++;
    if (cap_if.ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b exp=0", cap_if.ovf); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    int c;
    int n;
    restart_wave(10, 3, 8'd0);
    wait_done(60, c);
    n_checks++;
    if (c >= 60) begin n_fail++; $display("FAIL basic_timeout cycles=%0d limit=60", c); end
    n_checks++;
    if (cap_if.period !== 8'd10) begin n_fail++; $display("FAIL basic_period got=%0d exp=10", cap_if.period); end
    n_checks++;
    if (cap_if.high !== 8'd3) begin n_fail++; $display("FAIL basic_high got=%0d exp=3", cap_if.high); end
    n_checks++;
    if (cap_if.valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got=%b exp=1", cap_if.valid); end
    wait_done(20, c);
    n_checks++;
    if (c != 10) begin n_fail++; $display("FAIL basic_done_spacing got=%0d exp=10", c); end
    n = 0;
    repeat (100) begin
      @(negedge clk);
      if (cap_if.done === 1'b1) n++;
    end
    n_checks++;
    if (n != 10) begin n_fail++; $display("FAIL basic_done_count got=%0d exp=10", n); end
  endtask

  task automatic test_prescale();
    int c;
    restart_wave(10, 3, 8'd1);
    wait_done(60, c);
    n_checks++;
    if (c >= 60) begin n_fail++; $display("FAIL pre1_timeout cycles=%0d limit=60", c); end
    n_checks++;
    if (cap_if.period !== 8'd5) begin n_fail++; $display("FAIL pre1_period got=%0d exp=5", cap_if.period); end
    n_checks++;
    if (cap_if.high !== 8'd1) begin n_fail++; $display("FAIL pre1_high got=%0d exp=1", cap_if.high); end
    restart_wave(100, 25, 8'd4);
    wait_done(400, c);
    n_checks++;
    if (c >= 400) begin n_fail++; $display("FAIL pre4_timeout cycles=%0d limit=400", c); end
    n_checks++;
    if (cap_if.period !== 8'd20) begin n_fail++; $display("FAIL pre4_period got=%0d exp=20", cap_if.period); end
    n_checks++;
    if (cap_if.high !== 8'd5) begin n_fail++; $display("FAIL pre4_high got=%0d exp=5", cap_if.high); end
  endtask

  task automatic test_overflow();
    int c;
    int d0;
    cap_if.en = 1'b0;
    wf_on = 1'b0;
    @(negedge clk);
    cap_if.pwm_in = 1'b0;
    cap_if.pre = 8'd0;
    repeat (10) @(negedge clk);
    cap_if.en = 1'b1;
    repeat (5) @(negedge clk);
    d0 = done_total;
    cap_if.pwm_in = 1'b1;
    // rise seen 3 clk after the pin, then 256 ticks to reach 255 with tick
    repeat (258) @(negedge clk);
    n_checks++;
    if (cap_if.ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_early got=%b exp=0", cap_if.ovf); end
    @(negedge clk);
    n_checks++;
    if (cap_if.ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set got=%b exp=1", cap_if.ovf); end
    n_checks++;
    if (cap_if.period !== 8'd20 || cap_if.high !== 8'd5 || cap_if.valid !== 1'b1)
      begin n_fail++; $display("FAIL ovf_retain got=%0d/%0d/%b exp=20/5/1", cap_if.period, cap_if.high, cap_if.valid); end
    n_checks++;
    if (done_total != d0) begin n_fail++; $display("FAIL ovf_no_done got=%0d exp=%0d", done_total, d0); end
    wf_per = 10;
    wf_high = 3;
    wf_phase = 0;
    wf_on = 1'b1;
    wait_done(60, c);
    n_checks++;
    if (c >= 60) begin n_fail++; $display("FAIL ovf_resume_timeout cycles=%0d limit=60", c); end
    n_checks++;
    if (cap_if.period !== 8'd10 || cap_if.high !== 8'd3)
      begin n_fail++; $display("FAIL ovf_resume got=%0d/%0d exp=10/3", cap_if.period, cap_if.high); end
    n_checks++;
    if (cap_if.ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got=%b exp=1", cap_if.ovf); end
    repeat (9) @(negedge clk);
    cap_if.clr = 1'b1;
    @(negedge clk);
    cap_if.clr = 1'b0;
    n_checks++;
    if (cap_if.done !== 1'b1) begin n_fail++; $display("FAIL clrcap_done got=%b exp=1", cap_if.done); end
    n_checks++;
    if (cap_if.period !== 8'd10 || cap_if.valid !== 1'b1)
      begin n_fail++; $display("FAIL clrcap_result got=%0d/%b exp=10/1", cap_if.period, cap_if.valid); end
    n_checks++;
    if (cap_if.ovf !== 1'b0) begin n_fail++; $display("FAIL clrcap_ovf got=%b exp=0", cap_if.ovf); end
    cap_if.clr = 1'b1;
    @(negedge clk);
    cap_if.clr = 1'b0;
    n_checks++;
    if (cap_if.period !== 8'd0 || cap_if.high !== 8'd0 || cap_if.valid !== 1'b0)
      begin n_fail++; $display("FAIL clr_alone got=%0d/%0d/%b exp=0/0/0", cap_if.period, cap_if.high, cap_if.valid); end
  endtask

  task automatic test_en_drop();
    int c;
    int d0;
    restart_wave(10, 3, 8'd0);
    wait_done(60, c);
    cap_if.en = 1'b0;
    d0 = done_total;
    repeat (40) @(negedge clk);
    n_checks++;
    if (done_total != d0) begin n_fail++; $display("FAIL endrop_no_done got=%0d exp=%0d", done_total, d0); end
    n_checks++;
    if (cap_if.period !== 8'd10 || cap_if.high !== 8'd3 || cap_if.valid !== 1'b1)
      begin n_fail++; $display("FAIL endrop_retain got=%0d/%0d/%b exp=10/3/1", cap_if.period, cap_if.high, cap_if.valid); end
    cap_if.en = 1'b1;
    wait_done(60, c);
    n_checks++;
    if (c < 12 || c > 21) begin n_fail++; $display("FAIL enrearm_latency got=%0d exp=12..21", c); end
    n_checks++;
    if (cap_if.period !== 8'd10) begin n_fail++; $display("FAIL enrearm_period got=%0d exp=10", cap_if.period); end
  endtask

  task automatic test_rst_mid();
    int c;
    restart_wave(10, 3, 8'd0);
    wait_done(60, c);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (cap_if.period !== 8'd0 || cap_if.high !== 8'd0 || cap_if.valid !== 1'b0 ||
        cap_if.done !== 1'b0 || cap_if.ovf !== 1'b0)
      begin n_fail++; $display("FAIL rstmid_outputs got=%0d/%0d/%b/%b/%b exp=0/0/0/0/0",
        cap_if.period, cap_if.high, cap_if.valid, cap_if.done, cap_if.ovf); end
    @(negedge clk);
    rst = 1'b0;
    wait_done(60, c);
    n_checks++;
    if (c >= 60) begin n_fail++; $display("FAIL rstmid_timeout cycles=%0d limit=60", c); end
    n_checks++;
    if (cap_if.period !== 8'd10 || cap_if.high !== 8'd3 || cap_if.valid !== 1'b1)
      begin n_fail++; $display("FAIL rstmid_resume got=%0d/%0d/%b exp=10/3/1", cap_if.period, cap_if.high, cap_if.valid); end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    done_total = 0;
    wf_on = 1'b0;
    wf_per = 10;
    wf_high = 3;
    wf_phase = 0;
    rst = 1'b1;
    test_reset();
    test_basic();
    test_prescale();
    test_overflow();
    test_en_drop();
    test_rst_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
